// File: rtl/mem_bus_arbiter.sv
// RAM-port arbiter: dcaches beat icaches, round-robin per class, grant held for a BLOCK_WORDS block; 1-cycle arbitration.
// Losers and stalled owners see wait=1 (ram_wait passes through); define ARB_PERF_EN for grant/stall counters.
module mem_bus_arbiter #(
  parameter int CPUS        = 2,
  parameter int BLOCK_WORDS = 2
) (
  input  logic                 CLK,
  input  logic                 n_rst,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*32-1:0]   daddr,
  input  logic [CPUS*32-1:0]   dstore,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS*32-1:0]   dload,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*32-1:0]   iaddr,
  output logic [CPUS-1:0]      iwait,
  output logic [CPUS*32-1:0]   iload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic                 ram_wait
`ifdef ARB_PERF_EN
  ,
  output logic [CPUS*32-1:0]   perf_dgrants,
  output logic [CPUS*32-1:0]   perf_igrants,
  output logic [31:0]          perf_stall
`endif
);

  localparam int CW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int PW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(BLOCK_WORDS - 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            owner_is_d_q, owner_is_d_d;
  logic [CW-1:0]   word_cnt_q, word_cnt_d;
  logic [PW-1:0]   d_rr_q, d_rr_d;
  logic [PW-1:0]   i_rr_q, i_rr_d;

  logic            d_found, i_found;
  logic [PW-1:0]   d_pick, i_pick, d_idx, i_idx;
  logic            own_req, release_now;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (int'(p) == CPUS - 1) ? '0 : p + PW'(1);
  endfunction

  // Cyclic search from each rr pointer; scanning downwards lets the nearest requester win.
  always_comb begin
    d_found = 1'b0;
    d_pick  = '0;
    d_idx   = '0;
    i_found = 1'b0;
    i_pick  = '0;
    i_idx   = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      d_idx = PW'((int'(d_rr_q) + k) % CPUS);
      if (dREN[d_idx] || dWEN[d_idx]) begin
        d_found = 1'b1;
        d_pick  = d_idx;
      end
      i_idx = PW'((int'(i_rr_q) + k) % CPUS);
      if (iREN[i_idx]) begin
        i_found = 1'b1;
        i_pick  = i_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    owner_is_d_d = owner_is_d_q;
    word_cnt_d   = word_cnt_q;
    d_rr_d       = d_rr_q;
    i_rr_d       = i_rr_q;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    dwait        = '1;
    iwait        = '1;
    dload        = '0;
    iload        = '0;
    own_req      = 1'b0;
    release_now  = 1'b0;

    case (state_q)
      IDLE: begin
        word_cnt_d = '0;
        if (d_found) begin
          state_d      = SERVE;
          owner_d      = d_pick;
          owner_is_d_d = 1'b1;
        end else if (i_found) begin
          state_d      = SERVE;
          owner_d      = i_pick;
          owner_is_d_d = 1'b0;
        end
      end

      SERVE: begin
        if (owner_is_d_q) begin
          own_req  = dREN[owner_q] || dWEN[owner_q];
          ramWEN   = dWEN[owner_q];
          ramREN   = dREN[owner_q] && !dWEN[owner_q];
          ramaddr  = daddr[32*owner_q +: 32];
          ramstore = dstore[32*owner_q +: 32];
        end else begin
          own_req  = iREN[owner_q];
          ramREN   = iREN[owner_q];
          ramaddr  = iaddr[32*owner_q +: 32];
        end

        if (!own_req) begin
          release_now = 1'b1;
        end else if (!ram_wait) begin
          if (owner_is_d_q) begin
            dwait[owner_q]          = 1'b0;
            dload[32*owner_q +: 32] = ramload;
          end else begin
            iwait[owner_q]          = 1'b0;
            iload[32*owner_q +: 32] = ramload;
          end
          word_cnt_d = word_cnt_q + CW'(1);
          if (word_cnt_q == LAST_WORD) begin
            release_now = 1'b1;
          end
        end

        if (release_now) begin
          state_d    = IDLE;
          word_cnt_d = '0;
          if (owner_is_d_q) begin
            d_rr_d = next_ptr(owner_q);
          end else begin
            i_rr_d = next_ptr(owner_q);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      owner_is_d_q <= 1'b0;
      word_cnt_q   <= '0;
      d_rr_q       <= '0;
      i_rr_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      owner_is_d_q <= owner_is_d_d;
      word_cnt_q   <= word_cnt_d;
      d_rr_q       <= d_rr_d;
      i_rr_q       <= i_rr_d;
    end
  end

`ifdef ARB_PERF_EN
  logic [CPUS*32-1:0] perf_dgrants_q, perf_igrants_q;
  logic [31:0]        perf_stall_q;
  logic               grant_evt;

  assign grant_evt = (state_q == IDLE) && (state_d == SERVE);

  always_ff @(posedge CLK or negedge n_rst) begin
    if (!n_rst) begin
      perf_dgrants_q <= '0;
      perf_igrants_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      for (int c = 0; c < CPUS; c++) begin
        if (grant_evt && owner_is_d_d && (int'(owner_d) == c)) begin
          perf_dgrants_q[32*c +: 32] <= perf_dgrants_q[32*c +: 32] + 32'd1;
        end
        if (grant_evt && !owner_is_d_d && (int'(owner_d) == c)) begin
          perf_igrants_q[32*c +: 32] <= perf_igrants_q[32*c +: 32] + 32'd1;
        end
      end
      if ((state_q == SERVE) && ram_wait) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_dgrants = perf_dgrants_q;
  assign perf_igrants = perf_igrants_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a transaction-level model predicts every cycle's outputs into a scoreboard.
module tb_mem_bus_arbiter;
  localparam int CPUS = 2;
  localparam int BW   = 2;

  logic                CLK = 1'b0;
  logic                n_rst;
  logic [CPUS-1:0]     dREN, dWEN, iREN;
  logic [CPUS*32-1:0]  daddr, dstore, iaddr;
  logic [CPUS-1:0]     dwait, iwait;
  logic [CPUS*32-1:0]  dload, iload;
  logic                ramREN, ramWEN, ram_wait;
  logic [31:0]         ramaddr, ramstore, ramload;
`ifdef ARB_PERF_EN
  logic [CPUS*32-1:0]  perf_dgrants, perf_igrants;
  logic [31:0]         perf_stall;
`endif

  mem_bus_arbiter #(.CPUS(CPUS), .BLOCK_WORDS(BW)) dut (
    .CLK(CLK), .n_rst(n_rst),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_wait(ram_wait)
`ifdef ARB_PERF_EN
    , .perf_dgrants(perf_dgrants), .perf_igrants(perf_igrants), .perf_stall(perf_stall)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [1:0]  dwait;
    logic [1:0]  iwait;
    logic [63:0] dload;
    logic [63:0] iload;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: who holds the bus, how many words it has moved, and whose turn is next per class.
  bit          m_busy, m_own_d;
  int          m_own, m_cnt, m_drr, m_irr;
  int unsigned m_pd[CPUS], m_pi[CPUS], m_ps;

  logic [CPUS*32-1:0] s_daddr, s_dstore, s_iaddr;

  function automatic logic [31:0] word_of(input logic [63:0] v, input int i);
    return 32'(v >> (32 * i));
  endfunction

  function automatic bit bit_of(input logic [1:0] v, input int i);
    return ((v >> i) & 2'b01) != 2'b00;
  endfunction

  task automatic model_step(input bit in_rst, output exp_t e);
    bit req, done;
    e = '0;
    e.dwait = 2'b11;
    e.iwait = 2'b11;
    if (in_rst) begin
      m_busy = 0; m_cnt = 0; m_drr = 0; m_irr = 0; m_own = 0; m_own_d = 0;
      for (int c = 0; c < CPUS; c++) begin m_pd[c] = 0; m_pi[c] = 0; end
      m_ps = 0;
      return;
    end
    if (!m_busy) begin
      for (int k = 0; k < CPUS && !m_busy; k++) begin
        int c = (m_drr + k) % CPUS;
        if (bit_of(dREN, c) || bit_of(dWEN, c)) begin
          m_busy = 1; m_own_d = 1; m_own = c; m_pd[c]++;
        end
      end
      for (int k = 0; k < CPUS && !m_busy; k++) begin
        int c = (m_irr + k) % CPUS;
        if (bit_of(iREN, c)) begin
          m_busy = 1; m_own_d = 0; m_own = c; m_pi[c]++;
        end
      end
      m_cnt = 0;
      return;
    end
    if (m_own_d) begin
      req     = bit_of(dREN, m_own) || bit_of(dWEN, m_own);
      e.wen   = bit_of(dWEN, m_own);
      e.ren   = bit_of(dREN, m_own) && !bit_of(dWEN, m_own);
      e.addr  = word_of(daddr, m_own);
      e.store = word_of(dstore, m_own);
    end else begin
      req     = bit_of(iREN, m_own);
      e.ren   = req;
      e.addr  = word_of(iaddr, m_own);
    end
    if (ram_wait) m_ps++;
    done = !req;
    if (req && !ram_wait) begin
      if (m_own_d) begin
        e.dwait = 2'b11 & ~(2'b01 << m_own);
        e.dload = 64'(ramload) << (32 * m_own);
      end else begin
        e.iwait = 2'b11 & ~(2'b01 << m_own);
        e.iload = 64'(ramload) << (32 * m_own);
      end
      m_cnt++;
      if (m_cnt == BW) done = 1;
    end
    if (done) begin
      m_busy = 0;
      m_cnt  = 0;
      if (m_own_d) m_drr = (m_own + 1) % CPUS;
      else         m_irr = (m_own + 1) % CPUS;
    end
  endtask

  task automatic cyc(input logic [1:0] dr, input logic [1:0] dw, input logic [1:0] ir,
                     input logic rw, input bit rst);
    exp_t e;
    @(negedge CLK);
    n_rst    = !rst;
    dREN     = dr;
    dWEN     = dw;
    iREN     = ir;
    ram_wait = rw;
    ramload  = $urandom;
    daddr    = s_daddr;
    dstore   = s_dstore;
    iaddr    = s_iaddr;
    model_step(rst, e);
    exp_q.push_back(e);
  endtask

  // Monitor: pops one prediction per cycle and compares the whole output vector.
  initial begin
    exp_t e, got;
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {ramREN, ramWEN, ramaddr, ramstore, dwait, iwait, dload, iload};
        checks++;
        if (got === e) begin
          passes++;
        end else begin
          $display("FAIL cycle@%0t got ren=%b wen=%b addr=%h store=%h dwait=%b iwait=%b dload=%h iload=%h | want ren=%b wen=%b addr=%h store=%h dwait=%b iwait=%b dload=%h iload=%h",
                   $time, got.ren, got.wen, got.addr, got.store, got.dwait, got.iwait, got.dload, got.iload,
                   e.ren, e.wen, e.addr, e.store, e.dwait, e.iwait, e.dload, e.iload);
        end
      end
    end
  end

  initial begin
    bit   dreq[CPUS], dwr[CPUS], ireq[CPUS];
    bit   did_rst;
    logic [1:0] dr, dw, ir;
    n_rst = 1'b0; dREN = '0; dWEN = '0; iREN = '0; ram_wait = 1'b0; ramload = '0;
    daddr = '0; dstore = '0; iaddr = '0;
    s_daddr = '0; s_dstore = '0; s_iaddr = '0;

    // Reset with requests present: outputs must stay idle.
    cyc(2'b11, 2'b00, 2'b11, 1'b0, 1);
    cyc(2'b11, 2'b00, 2'b11, 1'b0, 1);

    // Dcache0 two-word read block, then idle.
    s_daddr = {32'h0, 32'h100};
    cyc(2'b01, 2'b00, 2'b00, 1'b0, 0);
    cyc(2'b01, 2'b00, 2'b00, 1'b0, 0);
    s_daddr = {32'h0, 32'h104};
    cyc(2'b01, 2'b00, 2'b00, 1'b0, 0);
    cyc(2'b00, 2'b00, 2'b00, 1'b0, 0);

    // Both dcaches requesting: grants alternate.
    s_daddr = {32'h180, 32'h140};
    repeat (9) cyc(2'b11, 2'b00, 2'b00, 1'b0, 0);
    cyc(2'b00, 2'b00, 2'b00, 1'b0, 0);

    // Dcache0 versus icache1 in the same cycle.
    s_iaddr = {32'h400, 32'h0};
    repeat (7) cyc(2'b01, 2'b00, 2'b10, 1'b0, 0);
    cyc(2'b00, 2'b00, 2'b00, 1'b0, 0);

    // Write wins over read on the same dcache.
    s_daddr  = {32'h200, 32'h0};
    s_dstore = {32'hDEADBEEF, 32'h0};
    repeat (4) cyc(2'b10, 2'b10, 2'b00, 1'b0, 0);
    cyc(2'b00, 2'b00, 2'b00, 1'b0, 0);

    // Owner drops its request while the RAM is still stalling.
    cyc(2'b01, 2'b00, 2'b00, 1'b1, 0);
    cyc(2'b01, 2'b00, 2'b00, 1'b1, 0);
    cyc(2'b00, 2'b00, 2'b00, 1'b1, 0);
    cyc(2'b01, 2'b00, 2'b00, 1'b0, 0);
    cyc(2'b01, 2'b00, 2'b00, 1'b0, 0);
    cyc(2'b00, 2'b00, 2'b00, 1'b0, 0);

    // Random traffic with sticky requests and one reset in the middle of a transfer.
    for (int c = 0; c < CPUS; c++) begin dreq[c] = 0; dwr[c] = 0; ireq[c] = 0; end
    did_rst = 0;
    for (int n = 0; n < 600; n++) begin
      dr = '0; dw = '0; ir = '0;
      for (int c = 0; c < CPUS; c++) begin
        if ($urandom_range(5) == 0) begin dreq[c] = !dreq[c]; dwr[c] = $urandom_range(1) == 1; end
        if ($urandom_range(5) == 0) ireq[c] = !ireq[c];
        dw[c] = dreq[c] && dwr[c];
        dr[c] = dreq[c] && (!dwr[c] || ($urandom_range(1) == 1));
        ir[c] = ireq[c];
      end
      s_daddr  = {$urandom, $urandom};
      s_dstore = {$urandom, $urandom};
      s_iaddr  = {$urandom, $urandom};
      if (n >= 300 && !did_rst && m_busy) begin
        did_rst = 1;
        cyc(dr, dw, ir, 1'b0, 1);
      end else begin
        cyc(dr, dw, ir, ($urandom_range(2) == 0), 0);
      end
    end
    repeat (3) cyc(2'b00, 2'b00, 2'b00, 1'b0, 0);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge CLK);
    #4;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain: %0d predictions left, want 0", exp_q.size());

`ifdef ARB_PERF_EN
    for (int c = 0; c < CPUS; c++) begin
      checks++;
      if (word_of(perf_dgrants, c) === m_pd[c]) passes++;
      else $display("FAIL perf_dgrants[%0d] got %0d want %0d", c, word_of(perf_dgrants, c), m_pd[c]);
      checks++;
      if (word_of(perf_igrants, c) === m_pi[c]) passes++;
      else $display("FAIL perf_igrants[%0d] got %0d want %0d", c, word_of(perf_igrants, c), m_pi[c]);
    end
    checks++;
    if (perf_stall === m_ps) passes++;
    else $display("FAIL perf_stall got %0d want %0d", perf_stall, m_ps);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
